// File: rtl/mesi_req_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : mesi_req_dispatcher
// Description : Pops coherence request words from the request FIFO, decodes
//               them into command/core, and drives them onto the snoop bus
//               with req/gnt/ack handshake, retry back-off and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mesi_req_dispatcher #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [3:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [1:0]  bus_cmd,
  output logic [1:0]  bus_core,
  input  logic        bus_ack,
  input  logic        bus_retry,
  output logic        busy,
  output logic        err_valid,
  output logic [3:0]  err_word,
  output logic [15:0] txn_count
);

  localparam int C_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int C_RTY_W = $clog2(MAX_RETRY + 1);
  localparam int C_BOF_W = $clog2(BACKOFF_CYCLES + 1);

  localparam logic [C_TMR_W-1:0] C_TIMEOUT  = C_TMR_W'(TIMEOUT_CYCLES);
  localparam logic [C_RTY_W-1:0] C_RTY_MAX  = C_RTY_W'(MAX_RETRY);
  localparam logic [C_BOF_W-1:0] C_BOF_LAST = C_BOF_W'(BACKOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POP      = 3'd1,
    S_LATCH    = 3'd2,
    S_REQ      = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_BACKOFF  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_req_word;
  logic [C_TMR_W-1:0]  r_timer;
  logic [C_RTY_W-1:0]  r_retry_cnt;
  logic [C_BOF_W-1:0]  r_backoff;
  logic                r_err_valid;
  logic [3:0]          r_err_word;
  logic [15:0]         r_txn_count;

  logic                w_on_bus;
  logic                w_timeout;
  logic                w_drop;
  logic                w_ack;
  logic                w_retry;

  // The timer counts the current REQ/WAIT_ACK cycle, so the limit is hit on
  // the TIMEOUT_CYCLES-th cycle spent on the bus for this attempt.
  assign w_on_bus  = (r_state == S_REQ) || (r_state == S_WAIT_ACK);
  assign w_timeout = w_on_bus && ((r_timer + 1'b1) == C_TIMEOUT);

  // State register; reset drops bus_req immediately since it is decoded from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and event decode; ack beats timeout, timeout beats retry.
  always_comb begin
    w_state_next = r_state;
    w_drop       = 1'b0;
    w_ack        = 1'b0;
    w_retry      = 1'b0;
    case (r_state)
      S_IDLE:  if (!fifo_empty) w_state_next = S_POP;
      S_POP:   w_state_next = S_LATCH;
      S_LATCH: w_state_next = S_REQ;
      S_REQ: begin
        if (w_timeout) begin
          w_drop       = 1'b1;
          w_state_next = S_IDLE;
        end else if (bus_gnt) begin
          w_state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (bus_ack) begin
          w_ack        = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_drop       = 1'b1;
          w_state_next = S_IDLE;
        end else if (bus_retry) begin
          if (r_retry_cnt == C_RTY_MAX) begin
            w_drop       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_retry      = 1'b1;
            w_state_next = S_BACKOFF;
          end
        end
      end
      S_BACKOFF: if (r_backoff == C_BOF_LAST) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request word, attempt timer, retry and back-off counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_word  <= '0;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_backoff   <= '0;
    end else begin
      if (r_state == S_LATCH) r_req_word <= fifo_rd_data;
      r_timer   <= w_on_bus ? r_timer + 1'b1 : '0;
      r_backoff <= (r_state == S_BACKOFF) ? r_backoff + 1'b1 : '0;
      if (r_state == S_LATCH) r_retry_cnt <= '0;
      else if (w_retry)       r_retry_cnt <= r_retry_cnt + 1'b1;
    end
  end

  // Drop reporting and saturating completed-transaction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_valid <= 1'b0;
      r_err_word  <= '0;
      r_txn_count <= '0;
    end else begin
      r_err_valid <= w_drop;
      if (w_drop) r_err_word <= r_req_word;
      if (w_ack && (r_txn_count != 16'hFFFF)) r_txn_count <= r_txn_count + 16'd1;
    end
  end

  assign fifo_rd_en = (r_state == S_POP);
  assign bus_req    = w_on_bus;
  assign busy       = (r_state != S_IDLE);
  assign bus_cmd    = r_req_word[3:2];
  assign bus_core   = r_req_word[1:0];
  assign err_valid  = r_err_valid;
  assign err_word   = r_err_word;
  assign txn_count  = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_mesi_req_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesi_req_dispatcher
// Description : Directed self-checking bench. Stimulus tasks describe each
//               transaction at the script level and publish the expected
//               per-cycle outputs; a compare process checks them each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesi_req_dispatcher;

  localparam int TIMEOUT = 15;
  localparam int BACKOFF = 4;
  localparam int O_ACK   = 0;
  localparam int O_BOTH  = 1;
  localparam int O_RETRY = 2;
  localparam int O_DROP  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [3:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        bus_req;
  logic        bus_gnt;
  logic [1:0]  bus_cmd;
  logic [1:0]  bus_core;
  logic        bus_ack;
  logic        bus_retry;
  logic        busy;
  logic        err_valid;
  logic [3:0]  err_word;
  logic [15:0] txn_count;

  // expected outputs for the current cycle
  logic        chk_en;
  logic        e_rd, e_req, e_busy, e_err;
  logic [3:0]  e_word, e_err_word;
  logic [15:0] e_count;

  int n_chk = 0;
  int n_err = 0;

  mesi_req_dispatcher #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRY(3),
    .BACKOFF_CYCLES(BACKOFF)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_core(bus_core),
    .bus_ack(bus_ack), .bus_retry(bus_retry), .busy(busy),
    .err_valid(err_valid), .err_word(err_word), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, want);
    end
  endtask

  // per-cycle compare against the published expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("fifo_rd_en", {15'd0, fifo_rd_en}, {15'd0, e_rd});
      check("bus_req",    {15'd0, bus_req},    {15'd0, e_req});
      check("busy",       {15'd0, busy},       {15'd0, e_busy});
      check("err_valid",  {15'd0, err_valid},  {15'd0, e_err});
      check("err_word",   {12'd0, err_word},   {12'd0, e_err_word});
      check("txn_count",  txn_count,           e_count);
      if (e_req) begin
        check("bus_cmd",  {14'd0, bus_cmd},  {14'd0, e_word[3:2]});
        check("bus_core", {14'd0, bus_core}, {14'd0, e_word[1:0]});
      end
    end
  end

  // advance one cycle and publish what the outputs must be in it
  task automatic step(input logic rd, input logic rq, input logic bs, input logic er);
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_ack = 1'b0; bus_retry = 1'b0;
    e_rd = rd; e_req = rq; e_busy = bs; e_err = er;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // from an idle cycle: offer one word, end in the first cycle of bus_req
  task automatic start(input logic [3:0] w);
    fifo_empty = 1'b0; fifo_rd_data = w;
    step(1'b1, 1'b0, 1'b1, 1'b0);          // pop strobe
    fifo_empty = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);          // word captured this cycle
    step(1'b0, 1'b1, 1'b1, 1'b0);          // request on the bus
    e_word = w;
  endtask

  // one bus attempt: grant after d idle request cycles, then the response
  task automatic attempt(input int d, input int outc, input logic [3:0] w);
    repeat (d) step(1'b0, 1'b1, 1'b1, 1'b0);
    bus_gnt = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    case (outc)
      O_ACK, O_BOTH: begin
        bus_ack = 1'b1;
        if (outc == O_BOTH) bus_retry = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (e_count != 16'hFFFF) e_count = e_count + 16'd1;
      end
      O_RETRY: begin
        bus_retry = 1'b1;
        repeat (BACKOFF) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
      end
      default: begin
        bus_retry = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e_err_word = w;
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; fifo_rd_data = 4'h0;
    bus_gnt = 1'b0; bus_ack = 1'b0; bus_retry = 1'b0;
    chk_en = 1'b0;
    e_rd = 1'b0; e_req = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    e_word = 4'h0; e_err_word = 4'h0; e_count = 16'd0;
    #12;
    check("rst_req",   {15'd0, bus_req},   16'd0);
    check("rst_busy",  {15'd0, busy},      16'd0);
    check("rst_rd_en", {15'd0, fifo_rd_en}, 16'd0);
    check("rst_cmd",   {12'd0, bus_cmd, bus_core}, 16'd0);
    check("rst_count", txn_count, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;
    idle(3);

    // single request, grant one cycle after bus_req
    start(4'b0110);
    attempt(1, O_ACK, 4'b0110);
    check("single_count", txn_count, 16'd1);
    idle(2);

    // two retries then success
    start(4'b1011);
    attempt(0, O_RETRY, 4'b1011);
    attempt(2, O_RETRY, 4'b1011);
    attempt(0, O_ACK, 4'b1011);
    check("retry_count", txn_count, 16'd2);
    idle(2);

    // retry exhaustion
    start(4'b1100);
    repeat (3) attempt(0, O_RETRY, 4'b1100);
    attempt(1, O_DROP, 4'b1100);
    check("exhaust_word", {12'd0, err_word}, 16'h000C);
    check("exhaust_err",  {15'd0, err_valid}, 16'd1);
    idle(2);
    check("exhaust_count", txn_count, 16'd2);

    // timeout with grant never given
    start(4'b0001);
    repeat (TIMEOUT - 1) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    e_err_word = 4'b0001;
    check("timeout_word", {12'd0, err_word}, 16'h0001);
    idle(2);

    // ack on the very cycle the timer expires wins
    start(4'b0111);
    attempt(TIMEOUT - 2, O_ACK, 4'b0111);
    idle(1);

    // timeout while waiting for the ack
    start(4'b1001);
    bus_gnt = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (TIMEOUT - 2) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    e_err_word = 4'b1001;
    idle(2);

    // ack and retry together count as ack; next pop right after
    start(4'b0010);
    attempt(0, O_BOTH, 4'b0010);
    start(4'b1110);
    attempt(0, O_ACK, 4'b1110);
    check("b2b_count", txn_count, 16'd5);
    idle(2);

    // asynchronous reset in WAIT_ACK
    start(4'b0101);
    bus_gnt = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    #1 rst = 1'b1;
    e_req = 1'b0; e_busy = 1'b0; e_count = 16'd0; e_err_word = 4'h0;
    #1;
    check("arst_req",  {15'd0, bus_req}, 16'd0);
    check("arst_busy", {15'd0, busy},    16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("arst_count", txn_count, 16'd0);
    check("arst_cmd",   {12'd0, bus_cmd, bus_core}, 16'd0);
    idle(2);
    check("arst_err",   {15'd0, err_valid}, 16'd0);

    // saturation of the completed-transaction counter
    force dut.r_txn_count = 16'hFFFE;
    #1;
    release dut.r_txn_count;
    e_count = 16'hFFFE;
    idle(1);
    start(4'b0100);
    attempt(0, O_ACK, 4'b0100);
    start(4'b1000);
    attempt(0, O_ACK, 4'b1000);
    check("sat_count", txn_count, 16'hFFFF);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
